// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU (FETCH -> DECODE -> [MEM] -> FETCH).
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   instMemAddrBus/DataBus  instruction fetch address (PC) and word {opcode, operand}
//   dataMemAddrBus          data address (IR operand)
//   dataMemInDataBus        data read bus, dataMemOutDataBus = accumulator
//   mReadFlag/mWriteFlag    data-memory request, held while in MEM
//   mReady                  completes the MEM access (wait states while low)
//   accOut/aluOut/opcode    accumulator, combinational ALU result, IR opcode
//   halted                  high once HLT has executed
// Requires IADDR_W <= DADDR_W so jump targets fit in the operand field.
module acc_cpu_core #(
  parameter int DATA_W  = 8,
  parameter int IADDR_W = 4,
  parameter int DADDR_W = 4,
  localparam int INST_W = 4 + DADDR_W
) (
  input  logic               clock,
  input  logic               reset,
  output logic [IADDR_W-1:0] instMemAddrBus,
  input  logic [INST_W-1:0]  instMemDataBus,
  output logic [DADDR_W-1:0] dataMemAddrBus,
  input  logic [DATA_W-1:0]  dataMemInDataBus,
  output logic [DATA_W-1:0]  dataMemOutDataBus,
  output logic               mReadFlag,
  output logic               mWriteFlag,
  input  logic               mReady,
  output logic [DATA_W-1:0]  accOut,
  output logic [DATA_W-1:0]  aluOut,
  output logic [3:0]         opcode,
  output logic               halted
);

  typedef enum logic [1:0] {FETCH, DECODE, MEM, HALT} state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3,
                         OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
                         OP_NOT = 4'h8, OP_LDI = 4'h9, OP_ADDI = 4'hA, OP_JMP = 4'hB,
                         OP_JZ  = 4'hC, OP_JC  = 4'hD, OP_SHL = 4'hE, OP_HLT = 4'hF;

  state_t               state;
  logic [IADDR_W-1:0]   pc;
  logic [INST_W-1:0]    ir;
  logic [DATA_W-1:0]    acc;
  logic                 z, c;

  logic [3:0]           op;
  logic [DADDR_W-1:0]   arg;
  logic [DATA_W-1:0]    imm;
  logic [DATA_W:0]      alu_wide;   // {carry, result}
  logic                 acc_we, c_we, is_mem;

  assign op  = ir[INST_W-1:DADDR_W];
  assign arg = ir[DADDR_W-1:0];
  assign imm = DATA_W'(arg);
  // opcodes 1..7 go through MEM
  assign is_mem = !op[3] && (op != OP_NOP);

  assign instMemAddrBus    = pc;
  assign dataMemAddrBus    = arg;
  assign dataMemOutDataBus = acc;
  assign accOut            = acc;
  assign aluOut            = alu_wide[DATA_W-1:0];
  assign opcode            = op;

  // ALU decodes the current IR every cycle; the FSM decides when to commit.
  always_comb begin
    alu_wide = {c, acc};
    acc_we   = 1'b0;
    c_we     = 1'b0;
    case (op)
      OP_LDA:  begin alu_wide = {c, dataMemInDataBus};                      acc_we = 1'b1; end
      OP_ADD:  begin alu_wide = {1'b0, acc} + {1'b0, dataMemInDataBus};     acc_we = 1'b1; c_we = 1'b1; end
      // borrow lands in the extra bit when acc < mem
      OP_SUB:  begin alu_wide = {1'b0, acc} - {1'b0, dataMemInDataBus};     acc_we = 1'b1; c_we = 1'b1; end
      OP_AND:  begin alu_wide = {c, acc & dataMemInDataBus};                acc_we = 1'b1; end
      OP_OR:   begin alu_wide = {c, acc | dataMemInDataBus};                acc_we = 1'b1; end
      OP_XOR:  begin alu_wide = {c, acc ^ dataMemInDataBus};                acc_we = 1'b1; end
      OP_NOT:  begin alu_wide = {c, ~acc};                                  acc_we = 1'b1; end
      OP_LDI:  begin alu_wide = {c, imm};                                   acc_we = 1'b1; end
      OP_ADDI: begin alu_wide = {1'b0, acc} + {1'b0, imm};                  acc_we = 1'b1; c_we = 1'b1; end
      OP_SHL:  begin alu_wide = {acc, 1'b0};                                acc_we = 1'b1; c_we = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= '0;
      ir         <= '0;
      acc        <= '0;
      z          <= 1'b0;
      c          <= 1'b0;
      mReadFlag  <= 1'b0;
      mWriteFlag <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= instMemDataBus;
          pc    <= pc + IADDR_W'(1);
          state <= DECODE;
        end
        DECODE: begin
          if (is_mem) begin
            state      <= MEM;
            mReadFlag  <= (op != OP_STA);
            mWriteFlag <= (op == OP_STA);
          end else if (op == OP_HLT) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
            if (acc_we) begin
              acc <= alu_wide[DATA_W-1:0];
              z   <= (alu_wide[DATA_W-1:0] == '0);
            end
            if (c_we) c <= alu_wide[DATA_W];
            // not-taken branches keep the PC incremented in FETCH
            if ((op == OP_JMP) || (op == OP_JZ && z) || (op == OP_JC && c))
              pc <= arg[IADDR_W-1:0];
          end
        end
        MEM: begin
          if (mReady) begin
            state      <= FETCH;
            mReadFlag  <= 1'b0;
            mWriteFlag <= 1'b0;
            if (acc_we) begin
              acc <= alu_wide[DATA_W-1:0];
              z   <= (alu_wide[DATA_W-1:0] == '0);
            end
            if (c_we) c <= alu_wide[DATA_W];
          end
        end
        default: ;  // HALT: frozen until reset
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: default-width instance u0 and a wide
// instance u1 (DATA_W=16, DADDR_W=8, IADDR_W=6) sharing one clock.
module tb_acc_cpu_core;

  logic        clock;
  // default instance
  logic        rst0, rdy0;
  logic [3:0]  ia0, da0;
  logic [7:0]  id0, din0, dout0, acc0, alu0;
  logic [3:0]  op0;
  logic        rd0, wr0, hlt0;
  logic [7:0]  imem0 [16];
  logic [7:0]  dmem0 [16];
  // wide instance
  logic        rst1;
  logic [5:0]  ia1;
  logic [7:0]  da1;
  logic [11:0] id1;
  logic [15:0] din1, dout1, acc1, alu1;
  logic [3:0]  op1;
  logic        rd1, wr1, hlt1;
  logic [11:0] imem1 [64];
  logic [15:0] dmem1 [256];

  int n_chk = 0, n_fail = 0;
  // bus activity observed at each rising edge
  int rflag0 = 0, wflag0 = 0, wdone0 = 0, wflag1 = 0, wdone1 = 0;
  logic [3:0]  waddr0; logic [7:0]  wdata0;
  logic [7:0]  waddr1; logic [15:0] wdata1;
  int base_a, base_b;

  assign id0  = imem0[ia0];
  assign din0 = dmem0[da0];
  assign id1  = imem1[ia1];
  assign din1 = dmem1[da1];

  acc_cpu_core u0 (
    .clock(clock), .reset(rst0), .instMemAddrBus(ia0), .instMemDataBus(id0),
    .dataMemAddrBus(da0), .dataMemInDataBus(din0), .dataMemOutDataBus(dout0),
    .mReadFlag(rd0), .mWriteFlag(wr0), .mReady(rdy0), .accOut(acc0),
    .aluOut(alu0), .opcode(op0), .halted(hlt0)
  );

  acc_cpu_core #(.DATA_W(16), .IADDR_W(6), .DADDR_W(8)) u1 (
    .clock(clock), .reset(rst1), .instMemAddrBus(ia1), .instMemDataBus(id1),
    .dataMemAddrBus(da1), .dataMemInDataBus(din1), .dataMemOutDataBus(dout1),
    .mReadFlag(rd1), .mWriteFlag(wr1), .mReady(1'b1), .accOut(acc1),
    .aluOut(alu1), .opcode(op1), .halted(hlt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rd0) rflag0++;
    if (wr0) wflag0++;
    if (wr0 && rdy0) begin wdone0++; waddr0 = da0; wdata0 = dout0; end
    if (wr1) wflag1++;
    if (wr1) begin wdone1++; waddr1 = da1; wdata1 = dout1; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear0();
    for (int i = 0; i < 16; i++) imem0[i] = 8'h00;
  endtask

  task automatic clear1();
    for (int i = 0; i < 64; i++) imem1[i] = 12'h000;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rdy0 = 1'b1;
    clear0(); clear1();
    for (int i = 0; i < 16; i++)  dmem0[i] = 8'h00;
    for (int i = 0; i < 256; i++) dmem1[i] = 16'h0000;
    dmem0[3] = 8'h03; dmem0[4] = 8'h5A;
    #1;
    // ---- reset state
    check("rst_pc",  32'(ia0), 32'h0);
    check("rst_acc", 32'(acc0), 32'h0);
    check("rst_op",  32'(op0), 32'h0);
    check("rst_flags", 32'({rd0, wr0, hlt0}), 32'h0);

    // ---- LDI 5; ADDI 3; STA 2; HLT
    imem0[0] = 8'h95; imem0[1] = 8'hA3; imem0[2] = 8'h22; imem0[3] = 8'hF0;
    base_a = wflag0; base_b = wdone0;
    #2 rst0 = 1'b0;
    step(8);
    check("prog_not_halted_8", 32'(hlt0), 32'h0);
    step(1);
    check("prog_halted_9", 32'(hlt0), 32'h1);
    check("prog_acc", 32'(acc0), 32'h08);
    check("prog_wflag_cycles", 32'(wflag0 - base_a), 32'd1);
    check("prog_wr_count", 32'(wdone0 - base_b), 32'd1);
    check("prog_wr_addr", 32'(waddr0), 32'h2);
    check("prog_wr_data", 32'(wdata0), 32'h08);
    step(3);
    check("halt_pc_frozen", 32'(ia0), 32'h4);
    check("halt_flags_low", 32'({rd0, wr0}), 32'h0);

    // ---- 0xFF + 1 -> 0, C=1, Z=1; JZ and JC taken
    rst0 = 1'b1; clear0();
    imem0[0] = 8'h90; imem0[1] = 8'h80; imem0[2] = 8'hA1; imem0[3] = 8'hCA;
    imem0[10] = 8'hDC; imem0[12] = 8'hF0;
    #2 rst0 = 1'b0;
    step(4);
    check("not_acc", 32'(acc0), 32'hFF);
    step(1);
    check("addi_alu_comb", 32'(alu0), 32'h00);
    step(1);
    check("addi_wrap_acc", 32'(acc0), 32'h00);
    step(2);
    check("jz_taken_pc", 32'(ia0), 32'hA);
    step(2);
    check("jc_taken_pc", 32'(ia0), 32'hC);

    // ---- SUB 3 from 2 -> 0xFF, C=1, Z=0
    rst0 = 1'b1; clear0();
    imem0[0] = 8'h92; imem0[1] = 8'h43; imem0[2] = 8'hC8; imem0[3] = 8'hD9;
    imem0[9] = 8'hF0;
    #2 rst0 = 1'b0;
    step(5);
    check("sub_borrow_acc", 32'(acc0), 32'hFF);
    step(2);
    check("jz_not_taken_pc", 32'(ia0), 32'h3);
    step(2);
    check("jc_after_sub_pc", 32'(ia0), 32'h9);

    // ---- PC wrap through NOPs at 0xF
    rst0 = 1'b1; clear0();
    imem0[0] = 8'hBF;
    #2 rst0 = 1'b0;
    step(2);
    check("jmp_pc", 32'(ia0), 32'hF);
    step(1);
    check("pc_wrap", 32'(ia0), 32'h0);

    // ---- LDA 4 with three wait states
    rst0 = 1'b1; clear0(); rdy0 = 1'b0;
    imem0[0] = 8'h97; imem0[1] = 8'h14; imem0[2] = 8'hF0;
    #2 rst0 = 1'b0;
    step(4);
    base_a = rflag0;
    check("lda_rflag_set", 32'({rd0, wr0}), 32'h2);
    check("lda_alu_comb", 32'(alu0), 32'h5A);
    step(3);
    check("lda_wait_rflag", 32'(rd0), 32'h1);
    check("lda_wait_acc", 32'(acc0), 32'h07);
    rdy0 = 1'b1;
    step(1);
    check("lda_acc", 32'(acc0), 32'h5A);
    check("lda_rflag_drop", 32'(rd0), 32'h0);
    check("lda_rflag_cycles", 32'(rflag0 - base_a), 32'd4);

    // ---- reset during MEM of STA
    rst0 = 1'b1; clear0(); rdy0 = 1'b0;
    imem0[0] = 8'h9C; imem0[1] = 8'h26;
    #2 rst0 = 1'b0;
    base_b = wdone0;
    step(4);
    check("sta_wflag_set", 32'(wr0), 32'h1);
    #2 rst0 = 1'b1;
    #1;
    check("abort_wflag", 32'({rd0, wr0}), 32'h0);
    check("abort_acc", 32'(acc0), 32'h0);
    check("abort_pc", 32'(ia0), 32'h0);
    check("abort_op_halt", 32'({op0, hlt0}), 32'h0);
    check("abort_no_store", 32'(wdone0 - base_b), 32'd0);
    rdy0 = 1'b1; rst0 = 1'b0;
    step(1);
    check("restart_pc", 32'(ia0), 32'h1);
    check("restart_op", 32'(op0), 32'h9);

    // ---- wide instance: same program
    imem1[0] = 12'h905; imem1[1] = 12'hA03; imem1[2] = 12'h202; imem1[3] = 12'hF00;
    base_a = wflag1; base_b = wdone1;
    check("w_rst_acc", 32'(acc1), 32'h0);
    rst1 = 1'b0;
    step(8);
    check("w_not_halted_8", 32'(hlt1), 32'h0);
    step(1);
    check("w_halted_9", 32'(hlt1), 32'h1);
    check("w_acc", 32'(acc1), 32'h0008);
    check("w_wflag_cycles", 32'(wflag1 - base_a), 32'd1);
    check("w_wr_count", 32'(wdone1 - base_b), 32'd1);
    check("w_wr_addr", 32'(waddr1), 32'h02);
    check("w_wr_data", 32'(wdata1), 32'h0008);

    // ---- wide ADDI carry out of bit 15
    rst1 = 1'b1; clear1();
    imem1[0] = 12'h900; imem1[1] = 12'h800; imem1[2] = 12'hA01; imem1[3] = 12'hD20;
    imem1[32] = 12'hF00;
    #2 rst1 = 1'b0;
    step(4);
    check("w_not_acc", 32'(acc1), 32'hFFFF);
    step(2);
    check("w_addi_wrap", 32'(acc1), 32'h0000);
    step(2);
    check("w_jc_pc", 32'(ia1), 32'h20);
    step(2);
    check("w_halted", 32'(hlt1), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
